// File: rtl/amcp_pkg.sv
// amcp_pkg
// Shared definitions for the AMCP multi-cycle-path sender.
//   DATA_W       : width of the data word carried across the multi-cycle path
//   amcp_state_t : sender FSM state (READY = idle, BUSY = word in flight)
package amcp_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        READY = 1'b0,
        BUSY  = 1'b1
    } amcp_state_t;

endpackage : amcp_pkg

// File: rtl/plsgen.sv
// plsgen
// Turns each transition of a level or toggle input into a single-cycle pulse.
// The input must already be synchronous to clk.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the delayed copy
//   d     : synchronous toggle input
//   pulse : high for exactly one cycle after each transition of d
module plsgen (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Keep a one-cycle-delayed copy of d so we can see when it changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    // The input and its delayed copy differ only in the cycle after a
    // transition, which gives a one-cycle pulse.
    assign pulse = d ^ d_q;

endmodule : plsgen

// File: rtl/amcp_send.sv
// amcp_send
// Source side of a toggle-handshake multi-cycle-path (MCP) transfer. A word
// is captured into adata and a_en toggles to launch it. adata then stays
// stable until the receiving domain returns an acknowledge toggle.
// Optional feature (macro AMCP_SKID_EN): adds a one-word skid register. A
// second word can be accepted while one is in flight, and it is launched as
// soon as the acknowledge arrives.
// Ports:
//   aclk    : sole clock, rising edge
//   arst_n  : asynchronous active-low reset
//   adatain : source data word, sampled when a send is accepted
//   asend   : send request, honoured only when aready = 1
//   aq2_ack : acknowledge toggle, already synchronised into aclk
//   adata   : held data word crossing the multi-cycle path
//   a_en    : enable toggle, one transition per launched word
//   aready  : 1 = a send is accepted this cycle
module amcp_send
    import amcp_pkg::*;
(
    input  logic              aclk,
    input  logic              arst_n,
    input  logic [DATA_W-1:0] adatain,
    input  logic              asend,
    input  logic              aq2_ack,
    output logic [DATA_W-1:0] adata,
    output logic              a_en,
    output logic              aready
);

    amcp_state_t       state_q;
    logic [DATA_W-1:0] adata_q;
    logic              aen_q;
    logic              a_ack;

`ifdef AMCP_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic              skid_valid_q;
`endif

    // Each transition of the synchronised acknowledge toggle becomes a
    // one-cycle a_ack pulse.
    plsgen u_ackPulse (
        .clk   (aclk),
        .rst_n (arst_n),
        .d     (aq2_ack),
        .pulse (a_ack)
    );

`ifdef AMCP_SKID_EN
    // Sender FSM with skid buffer. A send that arrives while BUSY is parked
    // in the skid. On acknowledge, the parked word launches first. If no word
    // is parked, a send in the same cycle launches straight away. Otherwise
    // the FSM goes back to idle. aready is set to 0 whenever the skid is
    // occupied, so asend is never seen with a full skid.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= READY;
            adata_q      <= '0;
            aen_q        <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                READY: begin
                    if (asend) begin
                        adata_q <= adatain;
                        aen_q   <= ~aen_q;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (a_ack) begin
                        if (skid_valid_q) begin
                            adata_q      <= skid_q;
                            aen_q        <= ~aen_q;
                            skid_valid_q <= 1'b0;
                        end else if (asend) begin
                            adata_q <= adatain;
                            aen_q   <= ~aen_q;
                        end else begin
                            state_q <= READY;
                        end
                    end else if (asend && !skid_valid_q) begin
                        skid_q       <= adatain;
                        skid_valid_q <= 1'b1;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign aready = ~skid_valid_q;
`else
    // Sender FSM. In READY, a send captures the word and toggles a_en on the
    // same edge, so the launch takes zero cycles. In BUSY, sends are ignored
    // and the FSM waits for the acknowledge pulse. An acknowledge seen in
    // READY is spurious and has no effect.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= READY;
            adata_q <= '0;
            aen_q   <= 1'b0;
        end else begin
            case (state_q)
                READY: begin
                    if (asend) begin
                        adata_q <= adatain;
                        aen_q   <= ~aen_q;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (a_ack) begin
                        state_q <= READY;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    // aready comes only from the state register, so there is no path from
    // asend to aready.
    assign aready = (state_q == READY);
`endif

    assign adata = adata_q;
    assign a_en  = aen_q;

endmodule : amcp_send
